// File: rtl/src_arb_pkg.sv
// Shared types and constants for the SNES source arbiter.
// Optional feature macro: SRC_ARB_IR_RELEASE_EN (IR auto-release timer).
package src_arb_pkg;

    localparam int BTN_W   = 8;
    localparam int TIMER_W = 20;

    // Value driven on the owner port.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        KEY  = 2'b01,
        IR   = 2'b10,
        BTN  = 2'b11
    } owner_e;

    // DIP switch encoding.
    typedef enum logic [1:0] {
        MODE_AUTO = 2'b00,
        MODE_KEY  = 2'b01,
        MODE_IR   = 2'b10,
        MODE_BTN  = 2'b11
    } mode_e;

    // Auto-mode ownership FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_KEY = 2'b01,
        OWN_IR  = 2'b10,
        OWN_BTN = 2'b11
    } state_e;

    // Fixed priority among active sources: btn > key > ir; IDLE when none.
    function automatic state_e pick_source(input logic btn, input logic key, input logic ir);
        if (btn)      return OWN_BTN;
        else if (key) return OWN_KEY;
        else if (ir)  return OWN_IR;
        else          return IDLE;
    endfunction

    // Owner code presented for a given FSM state.
    function automatic owner_e owner_of(input state_e s);
        case (s)
            OWN_KEY: return KEY;
            OWN_IR:  return IR;
            OWN_BTN: return BTN;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that saturates at zero.
module hold_timer
    import src_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] val,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    // Load wins over counting; the count sticks at zero once reached.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/src_arbiter.sv
// Arbitrates keyboard, IR and button-board words onto one SNES button word,
// snapshotting the granted word on every console load rising edge.
// Optional feature macro: SRC_ARB_IR_RELEASE_EN clears the IR word after
// IR_RELEASE cycles without an IR strobe.
module src_arbiter
    import src_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 250000,
    parameter int IR_RELEASE  = 120000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       dip,
    input  logic [BTN_W-1:0] key_word,
    input  logic             key_valid,
    input  logic [BTN_W-1:0] ir_word,
    input  logic             ir_valid,
    input  logic [BTN_W-1:0] btn_word,
    input  logic             load,
    output logic [BTN_W-1:0] word_out,
    output logic [1:0]       owner,
    output logic             hold_active
);

    localparam logic [TIMER_W-1:0] HOLD_VAL = TIMER_W'(HOLD_CYCLES);

    logic [BTN_W-1:0]   key_q, ir_q, next_word, snap_word;
    logic               load_q, snap_pend;
    logic               key_act, ir_act, btn_act, own_act, auto_mode;
    logic               hold_load, hold_zero, hold_expire;
    logic [TIMER_W-1:0] hold_val, hold_count;
    state_e             state, next_state, first_src, handoff_src;
    owner_e             owner_r;

    assign auto_mode = (mode_e'(dip) == MODE_AUTO);
    assign key_act   = key_valid && (key_word != '0);
    assign ir_act    = ir_valid && (ir_word != '0);
    assign btn_act   = (btn_word != '0);
    assign own_act   = (state == OWN_KEY && key_act) ||
                       (state == OWN_IR  && ir_act)  ||
                       (state == OWN_BTN && btn_act);

    // Timer reads 1 (or 0) on the last held cycle: release on this edge.
    assign hold_expire = (hold_count <= TIMER_W'(1));

    assign first_src   = pick_source(btn_act, key_act, ir_act);
    assign handoff_src = pick_source(btn_act && state != OWN_BTN,
                                     key_act && state != OWN_KEY,
                                     ir_act  && state != OWN_IR);

`ifdef SRC_ARB_IR_RELEASE_EN
    localparam logic [TIMER_W-1:0] IR_REL_VAL = TIMER_W'(IR_RELEASE);
    logic [TIMER_W-1:0] ir_count;
    logic               ir_expire;
    logic               unused_ir_zero;

    hold_timer u_ir_release (
        .clk   (clk),
        .reset (reset),
        .load  (ir_valid),
        .val   (IR_REL_VAL),
        .count (ir_count),
        .zero  (unused_ir_zero)
    );

    assign ir_expire = (ir_count <= TIMER_W'(1));
`else
    logic unused_ir_release;
    assign unused_ir_release = ^IR_RELEASE;
`endif

    hold_timer u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .val   (hold_val),
        .count (hold_count),
        .zero  (hold_zero)
    );

    // Next ownership state and hold-timer reload decision.
    always_comb begin
        next_state = state;
        hold_load  = 1'b0;
        hold_val   = HOLD_VAL;
        if (!auto_mode) begin
            // Forced modes park the FSM in IDLE with the timer cleared.
            next_state = IDLE;
            hold_load  = 1'b1;
            hold_val   = '0;
        end else if (state == IDLE) begin
            next_state = first_src;
            hold_load  = (first_src != IDLE);
        end else if (own_act) begin
            hold_load = 1'b1;
        end else if (hold_expire) begin
            // Another active source takes over without an idle cycle.
            next_state = handoff_src;
            hold_load  = (handoff_src != IDLE);
        end
    end

    // Ownership FSM with registered owner output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner_r <= NONE;
        end else begin
            state   <= next_state;
            owner_r <= auto_mode ? owner_of(next_state) : owner_e'(dip);
        end
    end

    // Source latches; non-owner strobes still update their latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            ir_q  <= '0;
        end else begin
            if (key_valid)
                key_q <= key_word;
            if (ir_valid)
                ir_q <= ir_word;
`ifdef SRC_ARB_IR_RELEASE_EN
            else if (ir_expire)
                ir_q <= '0;
`endif
        end
    end

    // Word belonging to the current (pre-edge) owner.
    always_comb begin
        case (owner_r)
            KEY:     next_word = key_q;
            IR:      next_word = ir_q;
            BTN:     next_word = btn_word;
            default: next_word = '0;
        endcase
    end

    // Load edge captures the owner's word; it reaches word_out one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q    <= 1'b0;
            snap_pend <= 1'b0;
            snap_word <= '0;
            word_out  <= '0;
        end else begin
            if (snap_pend)
                word_out <= snap_word;
            snap_pend <= load && !load_q;
            snap_word <= next_word;
            load_q    <= load;
        end
    end

    assign owner       = owner_r;
    assign hold_active = !hold_zero;

endmodule

// File: tb/tb_src_arbiter.sv
// Bench for src_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a cycle-age reference model.
module tb_src_arbiter;

    localparam int H = 8;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dip;
    logic [7:0] key_word, ir_word, btn_word;
    logic       key_valid, ir_valid, load;
    logic [7:0] word_out;
    logic [1:0] owner;
    logic       hold_active;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner plus "edges since last grant/owner activity".
    int       m_owner, m_age, m_ir_age;
    logic [7:0] m_key, m_ir, m_word, m_pend_word;
    bit       m_pend, m_load_prev, m_prev_auto, m_hold;

    src_arbiter #(.HOLD_CYCLES(H), .IR_RELEASE(R)) dut (
        .clk         (clk),
        .reset       (reset),
        .dip         (dip),
        .key_word    (key_word),
        .key_valid   (key_valid),
        .ir_word     (ir_word),
        .ir_valid    (ir_valid),
        .btn_word    (btn_word),
        .load        (load),
        .word_out    (word_out),
        .owner       (owner),
        .hold_active (hold_active)
    );

    always #5 clk = ~clk;

    function automatic int pick(input bit b, input bit k, input bit i, input int excl);
        if (b && excl != 3) return 3;
        if (k && excl != 1) return 1;
        if (i && excl != 2) return 2;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at it.
    task automatic model_edge();
        logic [7:0] cur;
        bit ka, ia, ba;
        if (reset) begin
            m_owner = 0; m_age = 0; m_ir_age = 0;
            m_key = 0; m_ir = 0; m_word = 0; m_pend_word = 0;
            m_pend = 0; m_load_prev = 0; m_prev_auto = 0; m_hold = 0;
            return;
        end
        cur = (m_owner == 1) ? m_key : (m_owner == 2) ? m_ir :
              (m_owner == 3) ? btn_word : 8'h00;
        if (m_pend) m_word = m_pend_word;
        m_pend      = load && !m_load_prev;
        m_pend_word = cur;
        m_load_prev = load;
        ka = key_valid && key_word != 0;
        ia = ir_valid && ir_word != 0;
        ba = btn_word != 0;
        if (dip != 0) begin
            m_owner = int'(dip);
        end else if (!m_prev_auto || m_owner == 0) begin
            m_owner = pick(ba, ka, ia, 0);
            m_age = 0;
        end else if ((m_owner == 1 && ka) || (m_owner == 2 && ia) || (m_owner == 3 && ba)) begin
            m_age = 0;
        end else if (m_age + 1 >= H) begin
            m_owner = pick(ba, ka, ia, m_owner);
            m_age = 0;
        end else begin
            m_age++;
        end
        m_prev_auto = (dip == 0);
        m_hold = (dip == 0) && (m_owner != 0);
        if (key_valid) m_key = key_word;
        if (ir_valid) begin
            m_ir = ir_word;
            m_ir_age = 0;
        end else begin
            if (m_ir_age < 1000000) m_ir_age++;
`ifdef SRC_ARB_IR_RELEASE_EN
            if (m_ir_age >= R) m_ir = 8'h00;
`endif
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_owner", {6'b0, owner}, 8'(m_owner));
        check("model_hold", {7'b0, hold_active}, {7'b0, m_hold});
        check("model_word", word_out, m_word);
    endtask

    task automatic quiet();
        key_valid = 0; ir_valid = 0; key_word = 0; ir_word = 0;
        btn_word = 0; load = 0;
    endtask

    task automatic snap();
        load = 1; tick();
        load = 0; tick();
    endtask

    initial begin
        // Reset with every input active.
        reset = 1; dip = 2'b00;
        key_word = 8'hff; key_valid = 1; ir_word = 8'hff; ir_valid = 1;
        btn_word = 8'hff; load = 1;
        repeat (3) tick();
        check("rst_word", word_out, 8'h00);
        check("rst_owner", {6'b0, owner}, 8'h00);
        check("rst_hold", {7'b0, hold_active}, 8'h00);
        reset = 0; quiet();
        tick();

        // Auto grant to keyboard, then a frame snapshot.
        key_word = 8'h21; key_valid = 1; tick(); key_valid = 0;
        check("key_grant", {6'b0, owner}, 8'h01);
        snap();
        check("key_snap", word_out, 8'h21);
        repeat (H) tick();
        check("key_released", {6'b0, owner}, 8'h00);

        // Simultaneous activity: button board wins.
        key_word = 8'h01; key_valid = 1; ir_word = 8'h02; ir_valid = 1; btn_word = 8'h04;
        tick(); key_valid = 0; ir_valid = 0;
        check("simul_owner", {6'b0, owner}, 8'h03);
        snap();
        check("simul_snap", word_out, 8'h04);
        btn_word = 0;
        repeat (H + 1) tick();

        // Hold for exactly H cycles after the last owner strobe.
        key_word = 8'h33; key_valid = 1; tick(); key_valid = 0;
        check("hold_grant", {6'b0, owner}, 8'h01);
        for (int i = 1; i < H; i++) begin
            tick();
            check("hold_own", {6'b0, owner}, 8'h01);
            check("hold_active", {7'b0, hold_active}, 8'h01);
        end
        tick();
        check("release_owner", {6'b0, owner}, 8'h00);
        check("release_hold", {7'b0, hold_active}, 8'h00);

        // IR strobe on the release cycle takes over directly.
        key_valid = 1; tick(); key_valid = 0;
        repeat (H - 1) tick();
        ir_word = 8'h10; ir_valid = 1; tick(); ir_valid = 0;
        check("handoff_owner", {6'b0, owner}, 8'h02);
        repeat (H) tick();

        // Forced IR mode while the keyboard owns.
        key_word = 8'h55; key_valid = 1; tick(); key_valid = 0;
        check("pre_force", {6'b0, owner}, 8'h01);
        dip = 2'b10; tick();
        check("force_owner", {6'b0, owner}, 8'h02);
        check("force_hold", {7'b0, hold_active}, 8'h00);
        key_word = 8'h66; key_valid = 1; tick(); key_valid = 0;
        check("force_ignore_key", {6'b0, owner}, 8'h02);
        ir_word = 8'h44; ir_valid = 1; tick(); ir_valid = 0;
        snap();
        check("force_snap", word_out, 8'h44);
        dip = 2'b00; tick();
        check("back_to_auto", {6'b0, owner}, 8'h00);

        // IR release timing.
        ir_word = 8'h80; ir_valid = 1; tick(); ir_valid = 0;
        check("ir_grant", {6'b0, owner}, 8'h02);
        repeat (R) tick();
        snap();
`ifdef SRC_ARB_IR_RELEASE_EN
        check("ir_release_snap", word_out, 8'h00);
`else
        check("ir_hold_snap", word_out, 8'h80);
`endif
        repeat (H) tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) dip = 2'($urandom_range(0, 3));
            else if (dip != 0 && $urandom_range(0, 19) == 0) dip = 2'b00;
            key_valid = ($urandom_range(0, 9) == 0);
            key_word  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ir_valid  = ($urandom_range(0, 9) == 0);
            ir_word   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 11) == 0)
                btn_word = ($urandom_range(0, 3) != 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) load = ~load;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/src_arbiter.md
# src_arbiter

- Arbitrates between the keyboard decoder, the IR decoder and the button board for the single 8-bit SNES button word.
- Replaces the static DIP-selected mux in front of `snes_encoder`.
- In auto mode it grants ownership to the first source that shows activity, and holds it until that source has been idle for a programmable time.
- It freezes the granted word on each console `load` rising edge, so every SNES frame carries one coherent snapshot.

## Interface

Parameters:
- `HOLD_CYCLES`, default 250000: owner idle time before release (0.25 s at 1 MHz).
- `IR_RELEASE`, default 120000: IR auto-release time; used only with the configuration macro.

Ports:
- `clk` in 1: single clock (1 MHz divided clock).
- `reset` in 1: synchronous, active-high reset.
- `dip` in 2: mode. 00 = auto, 01 = force keyboard, 10 = force IR, 11 = force buttons.
- `key_word` in 8: decoded keyboard button word.
- `key_valid` in 1: one-cycle strobe; `key_word` is valid in that cycle.
- `ir_word` in 8: decoded IR button word.
- `ir_valid` in 1: one-cycle strobe; `ir_word` is valid in that cycle.
- `btn_word` in 8: live button board word, already inverted to active-high.
- `load` in 1: console latch, already synchronous to `clk`.
- `word_out` out 8: frame snapshot to `snes_encoder.d`.
- `owner` out 2: current grant. 00 = none, 01 = key, 10 = IR, 11 = btn.
- `hold_active` out 1: high while the hold timer is running.

## Operation

Source latching:
- `key_word` is captured into `key_q` on `key_valid`.
- `ir_word` is captured into `ir_q` on `ir_valid`.
- `btn_word` is used live.

Activity per source:
- key: `key_valid` with a nonzero `key_word`.
- IR: `ir_valid` with a nonzero `ir_word`.
- btn: `btn_word` is nonzero.

Auto-mode state machine (`dip`=00), states IDLE, OWN_KEY, OWN_IR, OWN_BTN:
- IDLE:
  - Grant goes to the first active source.
  - On simultaneous activity, priority is btn > key > ir.
  - The hold timer loads `HOLD_CYCLES`.
- OWN_x:
  - Owner activity reloads the timer.
  - Activity from non-owners is ignored, but their latches still update.
  - When the timer reaches 0, go to IDLE.
  - If another source is active in that same cycle, it gets the grant directly on the next cycle, with no idle cycle.

Forced modes (`dip`≠00):
- `owner` is fixed to the selected source. The timer is idle and `hold_active` is 0.

Mode changes:
- Any `dip` change takes effect the next cycle.
- Entering 00 starts in IDLE with the timer cleared.

Snapshot (`next_word`):
- Equals the owner's word: `key_q`, `ir_q` or `btn_word`.
- Equals 0 when `owner` is 00.

Reset:
- Puts the FSM in IDLE.
- Clears `key_q`, `ir_q`, `word_out`, `owner`, `hold_active` and the timer to 0.
- A reset mid-hold or mid-frame is honoured immediately, with no partial snapshot.

## Timing

- Strobe to latch: 1 cycle (captured at the edge where the strobe is high).
- Activity to `owner` update: 1 cycle.
- `load` rising edge is detected through a `load_q` register. `word_out` updates on the edge after the one where `load`=1 and `load_q`=0 (2 edges after `load` rises). It is stable otherwise.
- `load` held high does not cause a re-snapshot.
- A `load` rising edge in the same cycle as an owner change snapshots the pre-change owner's word.
- Timer: a 20-bit down-counter, saturating at 0. Release happens on the cycle after it reads 1, i.e. exactly `HOLD_CYCLES` cycles after the last owner activity.

## Configuration

Macro `SRC_ARB_IR_RELEASE_EN`:
- Defined:
  - A second counter clears `ir_q` to 0 after `IR_RELEASE` cycles without `ir_valid`, which models button release for remotes that only send repeats.
  - An `ir_valid` reloads this counter.
- Undefined:
  - `ir_q` holds until the next `ir_valid`. The counter and the `IR_RELEASE` parameter have no effect.

## Structure

Package `src_arb_pkg`:
- `owner_e` enum (NONE, KEY, IR, BTN).
- `mode_e` for the DIP encoding.
- `state_e` for the FSM.
- The width constant `BTN_W`=8.

Sub-module `hold_timer`:
- Loadable, saturating down-counter with `load`, `val` and `zero` ports.
- Instanced once for ownership hold, and once more for IR release when the macro is defined.

## Test plan

- **Reset:** `reset`=1 for 3 cycles with all inputs active → `word_out`=00, `owner`=00, `hold_active`=0.
- **Auto grant to keyboard:** `dip`=00, `key_valid` with `key_word`=8'h21, then a `load` pulse → `owner`=01 one cycle after the strobe; `word_out`=8'h21 two edges after `load` rises.
- **Simultaneous activity:** same cycle `key_valid` (8'h01), `ir_valid` (8'h02) and `btn_word`=8'h04 → `owner`=11, next snapshot 8'h04.
- **Hold and release:** `HOLD_CYCLES`=8, key owns, then no activity → `owner`=00 exactly 8 cycles after the last strobe. With `ir_valid` (8'h10) on the release cycle → `owner`=10 the next cycle.
- **Forced mode:** `dip`=10 while the keyboard owns → `owner`=10 next cycle; key strobes ignored; snapshot is `ir_q`.
- **Macro, IR release:** with `SRC_ARB_IR_RELEASE_EN` and `IR_RELEASE`=5, `ir_valid` 8'h80 then silence → `ir_q`=0 after 5 cycles and the next snapshot is 00. Without the macro the snapshot stays 8'h80.
